// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - register offsets and bit indices shared by the game timer blocks
package game_timer_pkg;

    localparam int DATA_W = 16;

    typedef logic [2:0] reg_sel_t;

    localparam reg_sel_t REG_STATUS   = 3'd0;
    localparam reg_sel_t REG_CONTROL  = 3'd1;
    localparam reg_sel_t REG_PERIOD_L = 3'd2;
    localparam reg_sel_t REG_PERIOD_H = 3'd3;
    localparam reg_sel_t REG_SNAP_L   = 3'd4;
    localparam reg_sel_t REG_SNAP_H   = 3'd5;
    localparam reg_sel_t REG_PRESCALE = 3'd6;
    localparam reg_sel_t REG_GLOBAL   = 3'd7;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int STATUS_TO  = 0;
    localparam int STATUS_RUN = 1;

endpackage

// File: rtl/game_timer_multi_if.sv
// rtl/game_timer_multi_if.sv - Avalon-MM slave bus bundle for the multi-channel timer
interface game_timer_multi_if
    import game_timer_pkg::*;
#(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/game_timer_channel.sv
// rtl/game_timer_channel.sv - one timer channel: prescaler, down-counter, period, snapshot, control/status
module game_timer_channel
    import game_timer_pkg::*;
#(
    parameter int          COUNT_W      = 32,
    parameter int          PRESC_W      = 8,
    parameter logic [31:0] RESET_PERIOD = 32'h4C4B3F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  reg_sel_t          reg_sel,
    input  logic [DATA_W-1:0] wdata,
    input  logic              global_start,
    output logic [DATA_W-1:0] rdata,
    output logic              pending
);
    localparam logic [COUNT_W-1:0] RST_PERIOD = RESET_PERIOD[COUNT_W-1:0];

    logic [COUNT_W-1:0] period_q, period_d, counter_q, counter_d, snap_q, snap_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d, presc_cnt_q, presc_cnt_d;
    logic cont_q, cont_d, ito_q, ito_d, run_q, run_d, to_q, to_d, zero_q, zero_d;
    logic tick, start, stop, period_wr;

    always_comb begin
        period_d    = period_q;
        counter_d   = counter_q;
        snap_d      = snap_q;
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        cont_d      = cont_q;
        ito_d       = ito_q;
        run_d       = run_q;
        to_d        = to_q;
        tick        = run_q && (presc_cnt_q == '0);
        start       = global_start || (wr_en && reg_sel == REG_CONTROL && wdata[CTRL_START]);
        stop        = wr_en && reg_sel == REG_CONTROL && wdata[CTRL_STOP];
        period_wr   = wr_en && (reg_sel == REG_PERIOD_L || reg_sel == REG_PERIOD_H);
        zero_d      = (counter_q == '0);

        if (zero_d && !zero_q) to_d = 1'b1;

        if (tick) begin
            presc_cnt_d = prescale_q;
            if (counter_q == '0) begin
                counter_d = period_q;
                if (!cont_q) run_d = 1'b0;
            end else begin
                counter_d = counter_q - COUNT_W'(1);
            end
        end else if (run_q) begin
            presc_cnt_d = presc_cnt_q - PRESC_W'(1);
        end

        if (stop)  run_d = 1'b0;
        if (start) run_d = 1'b1;

        if (wr_en) begin
            case (reg_sel)
                REG_STATUS:   to_d = 1'b0;
                REG_CONTROL: begin
                    cont_d = wdata[CTRL_CONT];
                    ito_d  = wdata[CTRL_ITO];
                end
                REG_PERIOD_L: period_d[15:0] = wdata;
                REG_PERIOD_H: period_d[COUNT_W-1:16] = wdata[COUNT_W-17:0];
                REG_SNAP_L, REG_SNAP_H: snap_d = counter_q;
                REG_PRESCALE: prescale_d = wdata[PRESC_W-1:0];
                default: ;
            endcase
        end

        // A new period restarts the channel from a clean, stopped state.
        if (period_wr) begin
            counter_d   = period_d;
            presc_cnt_d = prescale_q;
            run_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q    <= RST_PERIOD;
            counter_q   <= RST_PERIOD;
            snap_q      <= '0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            cont_q      <= 1'b0;
            ito_q       <= 1'b0;
            run_q       <= 1'b0;
            to_q        <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            period_q    <= period_d;
            counter_q   <= counter_d;
            snap_q      <= snap_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            cont_q      <= cont_d;
            ito_q       <= ito_d;
            run_q       <= run_d;
            to_q        <= to_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS: begin
                rdata[STATUS_RUN] = run_q;
                rdata[STATUS_TO]  = to_q;
            end
            REG_CONTROL: begin
                rdata[CTRL_CONT] = cont_q;
                rdata[CTRL_ITO]  = ito_q;
            end
            REG_PERIOD_L: rdata = period_q[15:0];
            REG_PERIOD_H: rdata = DATA_W'(period_q[COUNT_W-1:16]);
            REG_SNAP_L:   rdata = snap_q[15:0];
            REG_SNAP_H:   rdata = DATA_W'(snap_q[COUNT_W-1:16]);
            REG_PRESCALE: rdata = DATA_W'(prescale_q);
            default:      rdata = '0;
        endcase
    end

    assign pending = to_q & ito_q;

endmodule

// File: rtl/game_timer_multi.sv
// rtl/game_timer_multi.sv - multi-channel interval timer top: decode, read mux, GLOBAL register, irq
module game_timer_multi
    import game_timer_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          COUNT_W      = 32,
    parameter int          PRESC_W      = 8,
    parameter logic [31:0] RESET_PERIOD = 32'h4C4B3F
) (
    input  logic                 clk,
    input  logic                 reset_n,
    game_timer_multi_if.slave    bus,
    output logic                 irq
);
    localparam int ADDR_W = $clog2(NUM_CH) + 3;

    logic [ADDR_W-1:0] ch_field;
    reg_sel_t          reg_field;
    logic              wr;
    logic [NUM_CH-1:0] pending;
    logic [DATA_W-1:0] ch_rdata [NUM_CH];
    logic [DATA_W-1:0] readdata_q, readdata_d;

    assign ch_field  = bus.address >> 3;
    assign reg_field = bus.address[2:0];
    assign wr        = bus.chipselect && !bus.write_n;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        game_timer_channel #(
            .COUNT_W      (COUNT_W),
            .PRESC_W      (PRESC_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .wr_en        (wr && ch_field == ADDR_W'(i) && reg_field != REG_GLOBAL),
            .reg_sel      (reg_field),
            .wdata        (bus.writedata),
            .global_start (wr && reg_field == REG_GLOBAL && bus.writedata[i]),
            .rdata        (ch_rdata[i]),
            .pending      (pending[i])
        );
    end

    // GLOBAL is mirrored at offset 7 of every implemented channel.
    always_comb begin
        readdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_field == ADDR_W'(c))
                readdata_d = (reg_field == REG_GLOBAL) ? DATA_W'(pending) : ch_rdata[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= readdata_d;
    end

    assign bus.readdata = readdata_q;
    assign irq          = |pending;

endmodule

// File: tb/tb_game_timer_multi.sv
// tb/tb_game_timer_multi.sv - directed self-checking bench for game_timer_multi
module tb_game_timer_multi;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;
    int   n_run  = 0;
    int   n_fail = 0;

    game_timer_multi_if #(.ADDR_W(5)) bus_if ();

    game_timer_multi #(
        .NUM_CH       (4),
        .COUNT_W      (32),
        .PRESC_W      (8),
        .RESET_PERIOD (32'h4C4B3F)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus_if),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    // Returns the register state as it stood when the task was called.
    task automatic rdchk(input string tag, input logic [4:0] a, input logic [15:0] exp);
        bus_if.address = a;
        @(negedge clk);
        chk(tag, bus_if.readdata, exp);
    endtask

    task automatic wait_irq(input int limit, output int k);
        k = 0;
        while (k < limit && irq !== 1'b1) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus_if.address    = 5'd2;
        bus_if.writedata  = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        rst_n             = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_readdata", bus_if.readdata, 32'h0);
        chk("rst_irq", irq, 1'b0);
        rst_n = 1'b1;

        rdchk("ch0_period_l_rst", 5'd2, 16'h4B3F);
        rdchk("ch0_period_h_rst", 5'd3, 16'h004C);
        rdchk("ch0_status_rst", 5'd0, 16'h0000);
        chk("irq_idle", irq, 1'b0);

        // ch1 continuous, period 9, prescale 0 -> timeout every 10 clocks
        wr(5'd14, 16'd0);
        wr(5'd10, 16'd9);
        wr(5'd11, 16'd0);
        wr(5'd9, 16'h0007);
        wait_irq(30, k);
        chk("ch1_first_to_clocks", k, 10);
        rdchk("ch1_global_pending", 5'd15, 16'h0002);
        wr(5'd8, 16'h0000);
        chk("ch1_irq_cleared", irq, 1'b0);
        rdchk("ch1_status_run", 5'd8, 16'h0002);
        wait_irq(30, k);
        chk("ch1_second_to_clocks", k, 10 - 3);
        wr(5'd9, 16'h0008);
        wr(5'd8, 16'h0000);
        chk("ch1_stopped_irq", irq, 1'b0);
        rdchk("ch1_status_stopped", 5'd8, 16'h0000);

        // ch2 one-shot, period 3, prescale 4 -> runs for 20 clocks
        wr(5'd22, 16'd4);
        wr(5'd18, 16'd3);
        wr(5'd19, 16'd0);
        wr(5'd17, 16'h0004);
        repeat (19) @(negedge clk);
        rdchk("ch2_status_clk19", 5'd16, 16'h0003);
        rdchk("ch2_status_clk20", 5'd16, 16'h0001);
        wr(5'd20, 16'h0000);
        rdchk("ch2_counter_reloaded", 5'd20, 16'd3);
        wr(5'd16, 16'h0000);
        repeat (40) @(negedge clk);
        rdchk("ch2_no_second_to", 5'd16, 16'h0000);
        chk("ch2_irq_masked", irq, 1'b0);

        // GLOBAL start of ch0 and ch2, both period 50, prescale 0
        wr(5'd6, 16'd0);
        wr(5'd2, 16'd50);
        wr(5'd3, 16'd0);
        wr(5'd1, 16'h0002);
        wr(5'd22, 16'd0);
        wr(5'd18, 16'd50);
        wr(5'd19, 16'd0);
        wr(5'd17, 16'h0002);
        wr(5'd7, 16'h0005);
        wr(5'd4, 16'h0000);
        wr(5'd21, 16'h0000);
        rdchk("ch0_snap_after_global", 5'd4, 16'd50);
        rdchk("ch2_snap_one_later", 5'd20, 16'd49);
        rdchk("ch0_status_global", 5'd0, 16'h0002);
        rdchk("ch2_status_global", 5'd16, 16'h0002);

        // period write while running forces a stopped reload
        wr(5'd2, 16'd20);
        rdchk("ch0_status_period_wr", 5'd0, 16'h0000);
        wr(5'd5, 16'h0000);
        rdchk("ch0_counter_new_period", 5'd4, 16'd20);
        wr(5'd1, 16'h000E);
        rdchk("ch0_start_beats_stop", 5'd0, 16'h0002);
        wr(5'd1, 16'h0008);
        wr(5'd17, 16'h0008);

        // ch3 one-shot period 4: status write lands on the timeout edge
        wr(5'd30, 16'd0);
        wr(5'd26, 16'd4);
        wr(5'd27, 16'd0);
        wr(5'd25, 16'h0005);
        repeat (4) @(negedge clk);
        wr(5'd24, 16'h0000);
        chk("ch3_coincident_irq", irq, 1'b0);
        rdchk("ch3_coincident_status", 5'd24, 16'h0000);
        chk("ch3_coincident_irq_later", irq, 1'b0);

        // async reset in the middle of a count with an interrupt pending
        wr(5'd1, 16'h0006);
        wr(5'd25, 16'h0005);
        wait_irq(20, k);
        chk("ch3_to_clocks", k, 5);
        chk("ch3_irq_before_reset", irq, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_irq", irq, 1'b0);
        chk("async_rst_readdata", bus_if.readdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdchk("post_rst_ch0_period_l", 5'd2, 16'h4B3F);
        rdchk("post_rst_ch0_status", 5'd0, 16'h0000);
        rdchk("post_rst_ch3_status", 5'd24, 16'h0000);
        rdchk("post_rst_ch3_prescale", 5'd30, 16'h0000);
        rdchk("post_rst_ch3_snap", 5'd28, 16'h0000);
        rdchk("post_rst_global", 5'd7, 16'h0000);
        chk("post_rst_irq", irq, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
